pc_fetch_ctrl: RTL
==================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 redirect  input  1  SHALL be the taken-jump/flush request from jump detection (pc_jump).
REQ-005 redirect_addr  input  32  SHALL be the jump target (pc_jump_addr).
REQ-006 stall  input  1  SHALL, when high, make decode refuse the current fetch output.
REQ-007 imem_req  output  1  SHALL be the instruction-memory request.
REQ-008 imem_addr  output  32  SHALL be the request address, word aligned.
REQ-009 imem_gnt  input  1  SHALL accept the request in the same cycle as imem_req.
REQ-010 imem_rvalid  input  1  SHALL mark imem_rdata valid, at least 1 cycle after grant.
REQ-011 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-012 if_valid / if_pc / if_instr  output  1/32/32  SHALL be the fetched instruction to decode.
REQ-013 misalign_err  output  1  SHALL be the misaligned-redirect flag (see Configuration).

Function
REQ-014 FSM states: IDLE, REQ, WAIT; at most one imem request outstanding.
REQ-015 IDLE: one cycle after reset release, then REQ; imem_req=0.
REQ-016 REQ: imem_req=1, imem_addr=pc_q; on imem_gnt latch req_pc=pc_q, go WAIT; imem_req held, imem_addr stable until granted.
REQ-017 REQ SHALL hold imem_req=0 while the skid entry is full.
REQ-018 WAIT: on imem_rvalid go REQ with pc_q=req_pc+4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000).
REQ-019 Output register: loaded with {1, req_pc, imem_rdata} on rvalid if empty or (if_valid and !stall); held unchanged while if_valid and stall.
REQ-020 Skid buffer (1 entry): captures rvalid data when output register is held; drains into output register the first cycle stall=0; output order preserved.
REQ-021 if_valid SHALL drop the cycle after consumption (if_valid and !stall) when neither skid nor rvalid supplies a new word.
REQ-022 Redirect (priority over all else, including stall): next cycle if_valid=0, skid empty, pc_q=redirect_addr.
REQ-023 Redirect in WAIT without same-cycle rvalid: set kill; the next rvalid SHALL be discarded, kill cleared, go REQ at pc_q.
REQ-024 Redirect in WAIT with same-cycle rvalid: data discarded, go REQ.
REQ-025 Redirect in REQ with same-cycle gnt: go WAIT with kill=1; response discarded.
REQ-026 Redirect in REQ without gnt: imem_addr SHALL switch to redirect_addr next cycle (permitted exception to REQ-016).
REQ-027 Redirect while kill already set: kill stays set, pc_q updated to newest target.
REQ-028 Latency: redirect to first if_valid at target = 1 (to REQ) + grant wait + memory latency + 1 cycle.

Reset
REQ-029 On rst: state IDLE, pc_q=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, skid empty, kill=0, misalign_err=0.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; any rvalid while in IDLE SHALL be ignored.

Configuration
REQ-031 Macro FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_addr[1:0]!=0 SHALL pulse misalign_err for exactly 1 cycle after the redirect; fetch continues at {redirect_addr[31:2],2'b00}.
REQ-032 Macro undefined: misalign_err tied 0; redirect_addr[1:0] silently forced to 0.

Verification
REQ-033 Reset release, RESET_PC=0, zero-wait gnt, 1-cycle rvalid -> if_pc sequence 0x0,0x4,0x8 on consecutive fetches.
REQ-034 stall=1 for 3 cycles with if_pc=0x8 valid -> if_pc/if_instr held at 0x8, word 0xC captured in skid, imem_req=0 while skid full, 0xC presented the first cycle after stall drops.
REQ-035 redirect=1, addr 0x100, during WAIT for 0x10 -> 0x10 response discarded, next imem_addr=0x100, if_valid=0 until 0x100 returns.
REQ-036 redirect same cycle as gnt for 0x20, target 0x200 -> 0x20 data never reaches if_valid; next request 0x200.
REQ-037 pc_q=0xFFFF_FFFC fetched -> next imem_addr 0x0000_0000.
REQ-038 FETCH_MISALIGN_CHECK_EN defined, redirect addr 0x102 -> misalign_err high exactly 1 cycle, imem_addr 0x100; undefined -> misalign_err stays 0, imem_addr 0x100.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bundle: redirect request, instruction-memory handshake and decode-facing output.
// master = fetch controller, slave = memory/decode environment.
interface pc_fetch_ctrl_if;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign_err;

    modport master (
        input  redirect, redirect_addr, stall, imem_gnt, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err
    );

    modport slave (
        output redirect, redirect_addr, stall, imem_gnt, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr, misalign_err
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: one outstanding imem request, output register plus 1-entry skid, redirect/kill.
// Redirect-to-output latency 1 + grant wait + memory latency + 1; FETCH_MISALIGN_CHECK_EN enables misalign_err.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    pc_fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        kill_q, kill_d;
    logic        out_vld_q, out_vld_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        skid_vld_q, skid_vld_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;

    logic [31:0] tgt;
    logic        req;
    logic        deliver;
    logic        consume;
    logic        out_free;

    assign tgt = {bus.redirect_addr[31:2], 2'b00};
    // A full skid means the output is stalled; do not fetch another word until it drains.
    assign req = (state_q == S_REQ) && !skid_vld_q;

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = out_vld_q;
    assign bus.if_pc     = out_pc_q;
    assign bus.if_instr  = out_instr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            kill_q   <= kill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        kill_d   = kill_q;
        deliver  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (req && bus.imem_gnt) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_q;
                    kill_d   = bus.redirect;
                end
                if (bus.redirect) pc_d = tgt;
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                    if (!kill_q && !bus.redirect) begin
                        deliver = 1'b1;
                        pc_d    = req_pc_q + 32'd4;
                    end
                end else if (bus.redirect) begin
                    kill_d = 1'b1;
                end
                if (bus.redirect) pc_d = tgt;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q    <= 1'b0;
            out_pc_q     <= 32'h0;
            out_instr_q  <= 32'h0;
            skid_vld_q   <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
        end else begin
            out_vld_q    <= out_vld_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
            skid_vld_q   <= skid_vld_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign consume  = out_vld_q && !bus.stall;
    assign out_free = !out_vld_q || consume;

    always_comb begin
        out_vld_d    = out_vld_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        skid_vld_d   = skid_vld_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (bus.redirect) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_free) begin
            // Skid holds the older word, so it drains first to keep program order.
            if (skid_vld_q) begin
                out_vld_d   = 1'b1;
                out_pc_d    = skid_pc_q;
                out_instr_d = skid_instr_q;
                skid_vld_d  = deliver;
                if (deliver) begin
                    skid_pc_d    = req_pc_q;
                    skid_instr_d = bus.imem_rdata;
                end
            end else if (deliver) begin
                out_vld_d   = 1'b1;
                out_pc_d    = req_pc_q;
                out_instr_d = bus.imem_rdata;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (deliver) begin
            skid_vld_d   = 1'b1;
            skid_pc_d    = req_pc_q;
            skid_instr_d = bus.imem_rdata;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_q, mis_d;

    assign mis_d            = bus.redirect && (bus.redirect_addr[1:0] != 2'b00);
    assign bus.misalign_err = mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mis_q <= 1'b0;
        else     mis_q <= mis_d;
    end
`else
    assign bus.misalign_err = 1'b0;
`endif

endmodule
